// File: rtl/signal_cfg_shadow.sv
// Shadow/active configuration register: software writes a shadow word by word, and a commit copies it atomically to cfg_data at a sync boundary.
// Latency: write->shadow 1 clk, apply->cfg_data/applied 1 clk, rd_addr->rd_data 1 clk. Writes stall (wr_ready=0) while a commit is pending.
module signal_cfg_shadow #(
    parameter int CFG_WIDTH  = 848,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 27,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  commit,
    input  logic                  sync,
    input  logic                  sync_bypass,
    output logic                  pending,
    output logic                  applied,
    input  logic                  rd_sel,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [CFG_WIDTH-1:0]  cfg_data
);

    localparam int PADW      = NUM_WORDS * WORD_WIDTH;
    localparam int LAST_BITS = CFG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
    localparam logic [WORD_WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WORD_WIDTH-1:0] LAST_MASK = ALL_ONES >> (WORD_WIDTH - LAST_BITS);

    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] words_t;

    words_t                shadow_q, shadow_d, active_w;
    logic [PADW-1:0]       shadow_flat;
    logic [CFG_WIDTH-1:0]  cfg_q, cfg_d;
    logic [WORD_WIDTH-1:0] rd_q, rd_d;
    logic                  pending_q, pending_d;
    logic                  applied_q;
    logic                  wr_err_q, wr_err_d;
    logic                  wr_fire, addr_ok, apply;

    assign wr_fire  = wr_valid & ~pending_q;
    assign addr_ok  = {1'b0, wr_addr} < (ADDR_WIDTH + 1)'(NUM_WORDS);
    assign apply    = (pending_q | commit) & (sync | sync_bypass);
    assign active_w = PADW'(cfg_q);

    // The last word only carries LAST_BITS real bits; the rest never get stored.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_fire) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wr_addr == ADDR_WIDTH'(k))
                    shadow_d[k] = wr_data & ((k == NUM_WORDS - 1) ? LAST_MASK : ALL_ONES);
            end
        end
    end

    // Applying from shadow_d lets a write accepted in the apply cycle join the commit.
    assign shadow_flat = shadow_d;
    assign cfg_d       = apply ? shadow_flat[CFG_WIDTH-1:0] : cfg_q;
    assign pending_d   = apply ? 1'b0 : (commit | pending_q);
    assign wr_err_d    = wr_fire & ~addr_ok;

    always_comb begin
        rd_d = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (rd_addr == ADDR_WIDTH'(k))
                rd_d = rd_sel ? active_w[k] : shadow_q[k];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            shadow_q  <= '0;
            cfg_q     <= '0;
            rd_q      <= '0;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            cfg_q     <= cfg_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
            applied_q <= apply;
            wr_err_q  <= wr_err_d;
        end
    end

    assign wr_ready = ~pending_q;
    assign pending  = pending_q;
    assign applied  = applied_q;
    assign wr_err   = wr_err_q;
    assign rd_data  = rd_q;
    assign cfg_data = cfg_q;

endmodule

// File: tb/tb_signal_cfg_shadow.sv
// Bench for signal_cfg_shadow: directed scenarios plus random traffic, all scored against a word-array reference model.
module tb_signal_cfg_shadow;

    localparam int CW = 848;
    localparam int NW = 27;

    logic          aclk = 1'b0;
    logic          areset;
    logic          wr_valid, wr_ready, wr_err;
    logic [4:0]    wr_addr, rd_addr;
    logic [31:0]   wr_data, rd_data;
    logic          commit, sync, sync_bypass, pending, applied, rd_sel;
    logic [CW-1:0] cfg_data;

    signal_cfg_shadow dut (
        .aclk(aclk), .areset(areset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .commit(commit), .sync(sync), .sync_bypass(sync_bypass),
        .pending(pending), .applied(applied), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data), .cfg_data(cfg_data)
    );

    always #5 aclk = ~aclk;

    // Reference model: shadow/active as plain word arrays plus a pending flag.
    logic [31:0] m_sh  [NW];
    logic [31:0] m_act [NW];
    logic        m_pend;
    logic        e_applied, e_err;
    logic [31:0] e_rd;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_cfg();
        logic [NW*32-1:0] v;
        for (int k = 0; k < NW; k++) v[k*32 +: 32] = m_act[k];
        return v[CW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NW; k++) begin
            m_sh[k]  = '0;
            m_act[k] = '0;
        end
        m_pend = 1'b0;
    endtask

    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic c, input logic s, input logic b,
                        input logic rs, input logic [4:0] ra);
        logic acc, app;
        wr_valid = v; wr_addr = a; wr_data = d;
        commit = c; sync = s; sync_bypass = b;
        rd_sel = rs; rd_addr = ra;
        acc = v && !m_pend;
        app = (m_pend || c) && (s || b);
        e_rd = (ra < NW) ? (rs ? m_act[ra] : m_sh[ra]) : 32'h0;
        e_err = acc && (a >= NW);
        if (acc && a < NW) m_sh[a] = (a == NW - 1) ? (d & 32'h0000_FFFF) : d;
        if (app) m_act = m_sh;
        m_pend = app ? 1'b0 : (c ? 1'b1 : m_pend);
        e_applied = app;
        @(posedge aclk);
        #1;
        check("cfg_data", cfg_data, model_cfg());
        check("rd_data", CW'(rd_data), CW'(e_rd));
        check("applied", CW'(applied), CW'(e_applied));
        check("wr_err", CW'(wr_err), CW'(e_err));
        check("pending", CW'(pending), CW'(m_pend));
        check("wr_ready", CW'(wr_ready), CW'(!m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        areset = 1'b1;
        wr_valid = 0; wr_addr = 0; wr_data = 0; commit = 0; sync = 0;
        sync_bypass = 0; rd_sel = 0; rd_addr = 0;
        model_reset();
        #12;
        check("rst_cfg", cfg_data, '0);
        check("rst_rd", CW'(rd_data), '0);
        check("rst_pending", CW'(pending), '0);
        check("rst_applied", CW'(applied), '0);
        check("rst_err", CW'(wr_err), '0);
        check("rst_ready", CW'(wr_ready), CW'(1));
        @(posedge aclk); #1;
        areset = 1'b0;

        // Bypass commit of word 0.
        step(1, 0, 32'h0000_1234, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 1, 0);
        check("w0_low16", CW'(cfg_data[15:0]), CW'(16'h1234));
        idle(2);

        // Sync-gated commit with a write held while locked.
        step(1, 4, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 32'hAAAA_AAAA, 0, 0, 0, 1, 1);
        step(1, 1, 32'hAAAA_AAAA, 0, 1, 0, 1, 1);
        check("w4_active", CW'(cfg_data[159:128]), CW'(32'hDEAD_BEEF));
        step(1, 1, 32'hAAAA_AAAA, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("w1_shadow", CW'(rd_data), CW'(32'hAAAA_AAAA));

        // Partial last word and out-of-range write.
        step(1, 26, 32'hFFFF_5A5A, 0, 0, 0, 0, 0);
        step(1, 27, 32'h1111_2222, 0, 0, 0, 0, 26);
        step(0, 0, 0, 1, 0, 1, 0, 26);
        check("w26_active", CW'(cfg_data[847:832]), CW'(16'h5A5A));
        check("w26_shadow", CW'(rd_data), CW'(32'h0000_5A5A));
        idle(1);

        // Commit, sync and write in one cycle; then double commit before sync.
        step(1, 2, 32'h0BAD_CAFE, 1, 1, 0, 0, 0);
        check("w2_same_cycle", CW'(cfg_data[95:64]), CW'(32'h0BAD_CAFE));
        step(1, 3, 32'h3333_3333, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 3);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset while a commit is outstanding.
        step(1, 5, 32'h5555_5555, 0, 0, 1, 0, 0);
        step(1, 6, 32'h6666_6666, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, 1, 5);
        step(0, 0, 0, 1, 0, 0, 1, 5);
        wr_valid = 0; commit = 0; sync = 0; sync_bypass = 0;
        #2;
        areset = 1'b1;
        #1;
        model_reset();
        check("arst_pending", CW'(pending), '0);
        check("arst_cfg", cfg_data, '0);
        check("arst_rd", CW'(rd_data), '0);
        check("arst_ready", CW'(wr_ready), CW'(1));
        @(posedge aclk); #1;
        areset = 1'b0;
        step(0, 0, 0, 0, 1, 0, 0, 5);
        step(0, 0, 0, 0, 1, 0, 1, 6);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/signal_cfg_shadow.md
Name: signal_cfg_shadow

Overview:
- Upstream stage of the per-channel signal configuration slice; builds the 848-bit signal configuration word from 32-bit register writes.
- Holds a shadow copy that software writes freely. An atomic commit copies the shadow into the active copy at a waveform period boundary, so the generator never sees a half-updated offset/amp/freq/phase set.
- Sits between the AXI-lite register decoder and the slice's cfg_data input.

Parameters:
- CFG_WIDTH, 848, width of the active/shadow configuration word.
- WORD_WIDTH, 32, register write/read word width.
- NUM_WORDS, 27, ceil(CFG_WIDTH/WORD_WIDTH); number of addressable words.
- ADDR_WIDTH, 5, width of wr_addr/rd_addr; must satisfy 2^ADDR_WIDTH >= NUM_WORDS.

Ports:
- aclk  in  1  system clock; all logic on its rising edge.
- areset  in  1  reset; asynchronous, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_WIDTH  shadow word index.
- wr_data  in  WORD_WIDTH  write data.
- wr_err  out  1  one-cycle pulse: accepted write had an out-of-range address.
- commit  in  1  pulse: request transfer of shadow to active.
- sync  in  1  period-boundary pulse from the waveform generator.
- sync_bypass  in  1  1 = apply a commit without waiting for sync.
- pending  out  1  commit requested, not yet applied.
- applied  out  1  one-cycle pulse in the first cycle the new cfg_data is visible.
- rd_sel  in  1  0 = read shadow, 1 = read active.
- rd_addr  in  ADDR_WIDTH  readback word index.
- rd_data  out  WORD_WIDTH  readback data; registered, 1-cycle latency.
- cfg_data  out  CFG_WIDTH  active configuration, registered.

Behaviour:
- Reset (async assert, deassert synchronous to aclk):
  - shadow, cfg_data, rd_data = 0
  - pending, applied, wr_err = 0
  - wr_ready = 1
- Word layout: word k maps to bits [32k+31:32k].
  - Word 26 keeps bits [15:0] only, mapped to cfg_data[847:832].
  - Bits [31:16] of word 26 are dropped on write and read back as 0.
- Write handshake:
  - wr_ready = ~pending. The shadow is locked while a commit is outstanding.
  - An accepted write updates the shadow at that clock edge.
  - wr_valid while wr_ready = 0 is stalled, not dropped; the requester holds it.
- Out-of-range write (wr_addr >= NUM_WORDS):
  - Still accepted, but the shadow is unchanged.
  - wr_err pulses in the next cycle.
- Apply condition A (evaluated each cycle) = (pending | commit) & (sync | sync_bypass).
- When A is true:
  - cfg_data <= shadow merged with any write accepted in the same cycle; the same-cycle write is included.
  - pending <= 0.
  - applied pulses in the next cycle, coincident with the new cfg_data.
- When commit is high and A is false: pending <= 1.
- commit while already pending: no effect; one apply only.
- sync with pending = 0 and commit = 0: no change, no applied pulse.
- sync_bypass = 1: apply occurs in the cycle commit is seen. Latency commit→cfg_data = 1 clock.
- sync_bypass = 0: cfg_data changes on the edge following the first sync at or after commit.
- Readback:
  - rd_data <= (rd_sel ? active : shadow) word at rd_addr, one cycle after rd_addr is presented.
  - rd_addr out of range returns 0.
- Reset mid-pending:
  - The pending commit is discarded.
  - Shadow and active both return to 0.
  - No applied pulse.
- cfg_data changes only on an apply edge or reset; it never changes on a write.

Test Plan:
- Reset, then write word 0 = 0x0000_1234, commit with sync_bypass=1 → cfg_data[15:0]=0x1234 one cycle after commit; applied pulses once; pending never high.
- sync_bypass=0: write word 4 = 0xDEAD_BEEF, commit, sync 10 cycles later → pending=1 and wr_ready=0 for those 10 cycles; cfg_data[159:128]=0xDEADBEEF on the edge after sync; applied pulses once.
- While pending, hold wr_valid with word 1 = 0xAAAA_AAAA → write stalls until after apply, then lands in shadow only; active word 1 reads back unchanged via rd_sel=1.
- Write word 26 = 0xFFFF_5A5A, then write wr_addr=27 → cfg_data[847:832]=0x5A5A after commit; shadow readback of word 26 = 0x0000_5A5A; wr_err pulses exactly once for addr 27; shadow unchanged.
- commit, sync and write (word 2 = 0x0BAD_CAFE) all in the same cycle with pending=0 → cfg_data[95:64]=0x0BADCAFE next cycle; commit twice before sync → a single applied pulse.
- Assert areset while pending=1 → pending, cfg_data, shadow, rd_data cleared immediately (asynchronously); no applied pulse after release.
